prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 151 +++++++++++++++
 tb/tb_prog_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: holds the core in reset while a host streams
// instruction words into program memory and reads them back.
module prog_loader #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic              rxReady,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRData,
  output logic              cpuHold,
  output logic              err
);

  localparam int unsigned CNT_W = 4;

  localparam logic [7:0] CMD_ENTER = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_EXIT  = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B0,
    S_GET_B1,
    S_WRITE,
    S_SEND_LO,
    S_SEND_HI,
    S_RELEASE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  rd_buf;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         b0;
  logic               is_write;
  logic               rx_fire;

  // Handshake and strobe outputs are pure decodes of the state register.
  assign rxReady = (state == S_IDLE) || (state == S_GET_B0) || (state == S_GET_B1);
  assign txValid = (state == S_SEND_LO) || (state == S_SEND_HI);
  assign memWe   = (state == S_WRITE);
  assign memAddr = addr;
  assign txData  = (state == S_SEND_HI) ? 8'(rd_buf >> 8) : rd_buf[7:0];
  assign rx_fire = rxValid && rxReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      rd_buf   <= '0;
      cnt      <= '0;
      b0       <= '0;
      is_write <= 1'b0;
      memWData <= '0;
      cpuHold  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            case (rxData)
              CMD_ENTER: begin
                cpuHold <= 1'b1;
                err     <= 1'b0;
              end
              CMD_LOAD, CMD_WRITE: begin
                if (cpuHold) begin
                  is_write <= (rxData == CMD_WRITE);
                  state    <= S_GET_B0;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_READ: begin
                // Read port is combinational on addr, so capture at accept.
                if (cpuHold) begin
                  rd_buf <= memRData;
                  state  <= S_SEND_LO;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_EXIT: begin
                if (cpuHold) begin
                  cnt   <= CNT_W'(RELEASE_DLY);
                  state <= S_RELEASE;
                end else begin
                  err <= 1'b1;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_GET_B0: begin
          if (rx_fire) begin
            b0    <= rxData;
            state <= S_GET_B1;
          end
        end
        S_GET_B1: begin
          if (rx_fire) begin
            if (is_write) begin
              memWData <= DATA_W'({rxData, b0});
              state    <= S_WRITE;
            end else begin
              addr  <= ADDR_W'({rxData, b0});
              state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          addr  <= addr + ADDR_W'(1);
          state <= S_IDLE;
        end
        S_SEND_LO: begin
          if (txReady) state <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (txReady) begin
            addr  <= addr + ADDR_W'(1);
            state <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (cnt <= CNT_W'(1)) begin
            cnt     <= '0;
            cpuHold <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: host byte protocol, memory writes/reads,
// release timing and asynchronous reset behaviour.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [8:0]  memAddr;
  logic [11:0] memWData;
  logic        memWe;
  logic [11:0] memRData;
  logic        cpuHold;
  logic        err;

  int checks;
  int failures;
  int we_cnt;
  int we_snap;

  logic [11:0] mem [512];

  prog_loader #(.ADDR_W(9), .DATA_W(12), .RELEASE_DLY(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .txData   (txData),
    .txValid  (txValid),
    .txReady  (txReady),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memWe    (memWe),
    .memRData (memRData),
    .cpuHold  (cpuHold),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple program memory model with combinational read.
  assign memRData = mem[memAddr];
  always @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memWData;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    checks = checks + 1;
    assert (rxReady) else begin
      failures = failures + 1;
      $error("FAIL rx_timeout observed=rxReady=0 expected=rxReady=1 byte=0x%0h", b);
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    we_cnt   = 0;
    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
    mem[16]  = 12'hA5C;
    rst_n    = 1'b0;
    rxData   = 8'h00;
    rxValid  = 1'b0;
    txReady  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rxReady", 32'(rxReady), 32'd1);
    chk("rst_txValid", 32'(txValid), 32'd0);
    chk("rst_cpuHold", 32'(cpuHold), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_memWe",   32'(memWe),   32'd0);
    chk("rst_memAddr", 32'(memAddr), 32'h000);
    chk("rst_txData",  32'(txData),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // ENTER, LOAD_ADDR 0x134, WRITE 0xBCD
    send(8'hA5);
    chk("enter_hold", 32'(cpuHold), 32'd1);
    send(8'h01); send(8'h34); send(8'h01);
    chk("load_addr", 32'(memAddr), 32'h134);
    we_snap = we_cnt;
    send(8'h02); send(8'hCD); send(8'hFB);
    chk("wr_we",    32'(memWe),    32'd1);
    chk("wr_addr",  32'(memAddr),  32'h134);
    chk("wr_wdata", 32'(memWData), 32'hBCD);
    chk("wr_rxrdy", 32'(rxReady),  32'd0);
    @(posedge clk); #1;
    chk("wr_we_off",  32'(memWe),   32'd0);
    chk("wr_addr_inc", 32'(memAddr), 32'h135);
    chk("wr_one_pulse", 32'(we_cnt - we_snap), 32'd1);
    chk("wr_mem", 32'(mem[9'h134]), 32'hBCD);

    // Address wrap across two writes
    send(8'h01); send(8'hFF); send(8'h01);
    send(8'h02); send(8'h11); send(8'h02);
    chk("wrap_addr0",  32'(memAddr),  32'h1FF);
    chk("wrap_wdata0", 32'(memWData), 32'h211);
    send(8'h02); send(8'h22); send(8'h03);
    chk("wrap_addr1",  32'(memAddr),  32'h000);
    chk("wrap_wdata1", 32'(memWData), 32'h322);
    @(posedge clk); #1;
    chk("wrap_after", 32'(memAddr), 32'h001);

    // READ with back-pressure
    send(8'h01); send(8'h10); send(8'h00);
    send(8'h03);
    chk("rd_txValid_lo", 32'(txValid), 32'd1);
    chk("rd_lo", 32'(txData), 32'h5C);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rd_lo_stable", 32'({txValid, txData}), 32'h15C);
    end
    txReady = 1'b1;
    @(posedge clk); #1;
    chk("rd_hi", 32'({txValid, txData}), 32'h10A);
    @(posedge clk); #1;
    txReady = 1'b0;
    chk("rd_done_txValid", 32'(txValid), 32'd0);
    chk("rd_addr_inc", 32'(memAddr), 32'h011);
    chk("rd_rxReady", 32'(rxReady), 32'd1);

    // Unknown command while held
    send(8'h77);
    chk("unk_held_err", 32'(err), 32'd1);
    send(8'hA5);
    chk("enter_clr_err", 32'(err), 32'd0);
    chk("enter_held_noop", 32'(cpuHold), 32'd1);

    // EXIT with 4-cycle release
    send(8'h5A);
    chk("exit_hold", 32'(cpuHold), 32'd1);
    chk("exit_rxReady", 32'(rxReady), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("exit_hold_3", 32'({cpuHold, rxReady}), 32'b10);
    @(posedge clk); #1;
    chk("exit_hold_4", 32'({cpuHold, rxReady}), 32'b01);
    chk("exit_addr_kept", 32'(memAddr), 32'h011);

    // Commands without hold
    we_snap = we_cnt;
    send(8'h02);
    chk("nohold_err", 32'(err), 32'd1);
    chk("nohold_idle", 32'(rxReady), 32'd1);
    send(8'h11);
    chk("nohold_unk_err", 32'(err), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("nohold_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("nohold_addr", 32'(memAddr), 32'h011);
    send(8'hA5);
    chk("reenter_err", 32'(err), 32'd0);
    chk("reenter_hold", 32'(cpuHold), 32'd1);

    // Reset during SEND_HI
    send(8'h01); send(8'h10); send(8'h00);
    send(8'h03);
    txReady = 1'b1;
    @(posedge clk); #1;
    txReady = 1'b0;
    chk("pre_rst_hi", 32'({txValid, txData}), 32'h10A);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_txValid", 32'(txValid), 32'd0);
    chk("arst_cpuHold", 32'(cpuHold), 32'd0);
    chk("arst_rxReady", 32'(rxReady), 32'd1);
    chk("arst_addr",    32'(memAddr), 32'h000);
    chk("arst_txData",  32'(txData),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    we_snap = we_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("post_rst_rxReady", 32'(rxReady), 32'd1);
    chk("post_rst_addr", 32'(memAddr), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
